// File: rtl/transmissor_uart_if.sv
// transmissor_uart_if: host FIFO write port and serial line status of the UART transmitter
interface transmissor_uart_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic [DATA_BITS-1:0]        data_in;
    logic                        wr_en;
    logic                        full;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        tx;
    logic                        busy;
    logic                        done;
    modport master (output data_in, wr_en, input full, fifo_count, tx, busy, done);
    modport slave  (input data_in, wr_en, output full, fifo_count, tx, busy, done);
endinterface

// File: rtl/transmissor_uart.sv
// transmissor_uart: FIFO-buffered UART transmitter, one bit per clk_115200hz cycle
module transmissor_uart #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk_115200hz,
    input logic reset_n,
    transmissor_uart_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_BITS);
    typedef enum logic [2:0] {IDLE, START, DATA, PAR_BIT, STOP} state_t;
    state_t               state, state_d;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic [DATA_BITS-1:0] shift, shift_d;
    logic [BW-1:0]        bit_idx, bit_idx_d;
    logic                 stop_idx, stop_idx_d;
    logic                 acc, acc_d, tx_q, tx_d;
    logic                 push, pop, last_bit, last_stop;
    assign push           = bus.wr_en && !bus.full;
    assign last_bit       = bit_idx == BW'(DATA_BITS - 1);
    assign last_stop      = state == STOP && stop_idx == 1'(STOP_BITS - 1);
    // the final stop cycle may pop the next byte so frames run back-to-back
    assign pop            = (state == IDLE || last_stop) && count != '0;
    assign bus.full       = count == CW'(FIFO_DEPTH);
    assign bus.fifo_count = count;
    assign bus.busy       = state != IDLE;
    assign bus.done       = last_stop;
    assign bus.tx         = tx_q;
    always_comb begin
        state_d    = pop ? START :
                     state == START ? DATA :
                     state == DATA && last_bit ? (PARITY != 0 ? PAR_BIT : STOP) :
                     state == PAR_BIT ? STOP :
                     last_stop ? IDLE : state;
        shift_d    = pop ? mem[rd_ptr] : state_d == DATA ? shift >> 1 : shift;
        acc_d      = pop ? PARITY == 2 : state_d == DATA ? acc ^ shift[0] : acc;
        bit_idx_d  = state == DATA ? bit_idx + BW'(1) : '0;
        stop_idx_d = state == STOP ? stop_idx + 1'b1 : 1'b0;
        // tx is registered with the value belonging to the state being entered
        tx_d       = state_d == DATA ? shift[0] : state_d == PAR_BIT ? acc : state_d != START;
    end
    always_ff @(posedge clk_115200hz or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            shift    <= '0;
            acc      <= 1'b0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_d;
            count    <= count + CW'(push) - CW'(pop);
            wr_ptr   <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr   <= pop ? rd_ptr + AW'(1) : rd_ptr;
            shift    <= shift_d;
            acc      <= acc_d;
            bit_idx  <= bit_idx_d;
            stop_idx <= stop_idx_d;
            tx_q     <= tx_d;
        end
    end
    always_ff @(posedge clk_115200hz) begin
        if (push) mem[wr_ptr] <= bus.data_in;
    end
endmodule

// File: tb/tb_transmissor_uart.sv
// tb_transmissor_uart: frame-level model of four transmitter configurations plus directed literal checks
module tb_transmissor_uart;
    localparam int PAR [4] = '{0, 1, 2, 0};
    localparam int STP [4] = '{1, 1, 1, 2};
    logic       clk, reset_n;
    logic [3:0] wr;
    logic [7:0] dat [4];
    logic [3:0] tx_o, busy_o, done_o, full_o;
    logic [2:0] cnt_o [4];
    logic       active;
    int         checks = 0, errors = 0;
    logic [7:0] q [4][$];
    logic       fb [4][$];
    logic [7:0] rxq [$];
    logic [31:0] ct [4], cb [4], cd [4];

    transmissor_uart_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) b0 (), b1 (), b2 (), b3 ();
    transmissor_uart #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        d0 (.clk_115200hz(clk), .reset_n(reset_n), .bus(b0));
    transmissor_uart #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
        d1 (.clk_115200hz(clk), .reset_n(reset_n), .bus(b1));
    transmissor_uart #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
        d2 (.clk_115200hz(clk), .reset_n(reset_n), .bus(b2));
    transmissor_uart #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
        d3 (.clk_115200hz(clk), .reset_n(reset_n), .bus(b3));

    assign b0.wr_en = wr[0];
    assign b1.wr_en = wr[1];
    assign b2.wr_en = wr[2];
    assign b3.wr_en = wr[3];
    assign b0.data_in = dat[0];
    assign b1.data_in = dat[1];
    assign b2.data_in = dat[2];
    assign b3.data_in = dat[3];
    assign tx_o   = {b3.tx, b2.tx, b1.tx, b0.tx};
    assign busy_o = {b3.busy, b2.busy, b1.busy, b0.busy};
    assign done_o = {b3.done, b2.done, b1.done, b0.done};
    assign full_o = {b3.full, b2.full, b1.full, b0.full};
    assign cnt_o[0] = b0.fifo_count;
    assign cnt_o[1] = b1.fifo_count;
    assign cnt_o[2] = b2.fifo_count;
    assign cnt_o[3] = b3.fifo_count;
    assign active = busy_o != '0 || cnt_o[0] != '0 || cnt_o[1] != '0 || cnt_o[2] != '0 || cnt_o[3] != '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // a frame is the list of line levels it occupies, one per bit cycle
    function automatic void build(input int i, input logic [7:0] v);
        fb[i].push_back(1'b0);
        for (int k = 0; k < 8; k++) fb[i].push_back(v[k]);
        if (PAR[i] == 1) fb[i].push_back(^v);
        if (PAR[i] == 2) fb[i].push_back(~^v);
        for (int k = 0; k < STP[i]; k++) fb[i].push_back(1'b1);
    endfunction

    initial begin : model
        bit pop_now, push_now;
        forever begin
            @(posedge clk or negedge reset_n);
            for (int i = 0; i < 4; i++) begin
                if (!reset_n) begin
                    q[i].delete();
                    fb[i].delete();
                end else begin
                    pop_now  = fb[i].size() <= 1 && q[i].size() != 0;
                    push_now = wr[i] && q[i].size() < 4;
                    if (fb[i].size() != 0) void'(fb[i].pop_front());
                    if (pop_now) build(i, q[i].pop_front());
                    if (push_now) q[i].push_back(dat[i]);
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("m_tx%0d", i), 32'(tx_o[i]), 32'(fb[i].size() != 0 ? fb[i][0] : 1'b1));
                chk($sformatf("m_busy%0d", i), 32'(busy_o[i]), 32'(fb[i].size() != 0));
                chk($sformatf("m_done%0d", i), 32'(done_o[i]), 32'(fb[i].size() == 1));
                chk($sformatf("m_cnt%0d", i), 32'(cnt_o[i]), 32'(q[i].size()));
                chk($sformatf("m_full%0d", i), 32'(full_o[i]), 32'(q[i].size() == 4));
            end
        end
    end

    initial begin : rx
        int n;
        logic [7:0] sh;
        n = 0;
        sh = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) n = 0;
            else if (n == 0) begin
                if (tx_o[0] == 1'b0) n = 1;
            end else if (n <= 8) begin
                sh = {tx_o[0], sh[7:1]};
                n++;
            end else begin
                if (tx_o[0]) rxq.push_back(sh);
                n = 0;
            end
        end
    end

    task automatic put(input logic [3:0] m, input logic [7:0] v);
        @(negedge clk);
        wr = m;
        for (int i = 0; i < 4; i++) dat[i] = v;
    endtask

    task automatic collect(input int n);
        for (int i = 0; i < 4; i++) begin
            ct[i] = '0;
            cb[i] = '0;
            cd[i] = '0;
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                ct[i][k] = tx_o[i];
                cb[i][k] = busy_o[i];
                cd[i][k] = done_o[i];
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (active && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", 32'(active), 32'(0));
    endtask

    initial begin
        reset_n = 1'b0;
        wr = '0;
        for (int i = 0; i < 4; i++) dat[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_o), 32'hF);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        chk("rst_full", 32'(full_o), 32'h0);
        chk("rst_cnt", 32'(cnt_o[0]), 32'h0);
        reset_n = 1'b1;
        put(4'b0001, 8'h32);
        put(4'b0000, 8'hEE);
        collect(11);
        chk("t1_tx", ct[0], 32'b11001100100);
        chk("t1_done", cd[0], 32'h200);
        chk("t1_busy", cb[0], 32'h3FF);
        wait_idle();
        put(4'b0001, 8'h55);
        put(4'b0001, 8'hAA);
        put(4'b0000, 8'hEE);
        collect(20);
        chk("t2_tx", ct[0], 32'hEA955);
        chk("t2_done", cd[0], 32'h40100);
        chk("t2_busy", cb[0], 32'h7FFFF);
        wait_idle();
        rxq.delete();
        for (int k = 0; k < 6; k++) put(4'b0001, 8'h41 + 8'(k));
        put(4'b0000, 8'hEE);
        chk("t3_full", 32'(full_o[0]), 32'h1);
        chk("t3_cnt", 32'(cnt_o[0]), 32'h4);
        wait_idle();
        chk("t3_frames", 32'(rxq.size()), 32'h5);
        for (int k = 0; k < 5; k++) chk($sformatf("t3_byte%0d", k), 32'(rxq[k]), 32'h41 + 32'(k));
        put(4'b0110, 8'h07);
        put(4'b0000, 8'hEE);
        collect(12);
        chk("t4_even_tx", ct[1], 32'hE0E);
        chk("t4_odd_tx", ct[2], 32'hC0E);
        chk("t4_even_busy", cb[1], 32'h7FF);
        chk("t4_odd_busy", cb[2], 32'h7FF);
        chk("t4_even_done", cd[1], 32'h400);
        wait_idle();
        put(4'b1000, 8'hFF);
        put(4'b1000, 8'h00);
        put(4'b0000, 8'hEE);
        collect(22);
        chk("t5_tx", ct[3], 32'h3803FF);
        chk("t5_done", cd[3], 32'h100200);
        chk("t5_busy", cb[3], 32'h1FFFFF);
        wait_idle();
        put(4'b0001, 8'h12);
        put(4'b0001, 8'h34);
        put(4'b0001, 8'h56);
        put(4'b0000, 8'hEE);
        @(negedge clk);
        chk("t6_pre_cnt", 32'(cnt_o[0]), 32'h2);
        chk("t6_pre_busy", 32'(busy_o[0]), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_tx", 32'(tx_o[0]), 32'h1);
        chk("t6_busy", 32'(busy_o[0]), 32'h0);
        chk("t6_cnt", 32'(cnt_o[0]), 32'h0);
        chk("t6_full", 32'(full_o[0]), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("t6_idle_tx%0d", k), 32'(tx_o[0]), 32'h1);
            chk($sformatf("t6_idle_busy%0d", k), 32'(busy_o[0]), 32'h0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
